// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, function codes, display glyph nibbles and converter states
package calc_pkg;
  localparam int NUM_W = 14;
  localparam int DIG_W = 4;
  localparam int N_DIG = 4;
  localparam int ITER = 14;
  localparam int SH_W = N_DIG * DIG_W + NUM_W;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [2:0] FN_NUM = 3'b000;
  localparam logic [2:0] FN_A = 3'b001;
  localparam logic [2:0] FN_B = 3'b010;
  localparam logic [2:0] FN_C = 3'b011;
  localparam logic [2:0] FN_D = 3'b100;
  localparam logic [2:0] FN_ERR = 3'b101;
  localparam logic [3:0] GLY_A = 4'hA;
  localparam logic [3:0] GLY_B = 4'hB;
  localparam logic [3:0] GLY_C = 4'hC;
  localparam logic [3:0] GLY_D = 4'hD;
  localparam logic [3:0] GLY_E = 4'hE;
  localparam logic [3:0] GLY_F = 4'hF;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  // operator and error-word glyphs map to their function code; anything else is a number
  function automatic logic [2:0] glyph_code(input logic [3:0] th, h, t, o);
    return (th != 4'd0) ? FN_NUM :
           (h == GLY_E && t == GLY_F && o == GLY_F) ? FN_ERR :
           (h != 4'd0 || t != 4'd0) ? FN_NUM :
           (o == GLY_A) ? FN_A :
           (o == GLY_B) ? FN_B :
           (o == GLY_C) ? FN_C :
           (o == GLY_D) ? FN_D : FN_NUM;
  endfunction
endpackage

// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: digit request and result bundle for the BCD-to-binary converter
interface bcd_to_bin_if;
  import calc_pkg::*;
  logic start;
  logic [DIG_W-1:0] thuns;
  logic [DIG_W-1:0] huns;
  logic [DIG_W-1:0] tens;
  logic [DIG_W-1:0] ones;
  logic [NUM_W-1:0] number;
  logic [2:0] func;
  logic busy;
  logic done;
  logic err;
  modport master (output start, thuns, huns, tens, ones, input number, func, busy, done, err);
  modport slave (input start, thuns, huns, tens, ones, output number, func, busy, done, err);
endinterface

// File: rtl/bcd_nibble_adj.sv
// bcd_nibble_adj: reverse double-dabble correction, subtract 3 from a nibble of 8 or more
module bcd_nibble_adj (
  input logic [3:0] a,
  output logic [3:0] y
);
  assign y = (a >= 4'd8) ? a - 4'd3 : a;
endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: iterative 4-digit BCD to 14-bit binary converter with glyph decode (BCD2BIN_ERRCHK_EN enables invalid-digit check)
module bcd_to_bin
  import calc_pkg::*;
(
  input logic clk,
  input logic rst,
  bcd_to_bin_if.slave bus
);
  state_t state, state_n;
  logic [SH_W-1:0] shift, shift_n, sh, adj;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_W-1:0] number, number_n;
  logic [2:0] func, func_n, gly;
  logic err, err_n, bad;
  assign sh = shift >> 1;
  assign adj[NUM_W-1:0] = sh[NUM_W-1:0];
  for (genvar i = 0; i < N_DIG; i++) begin : g_adj
    bcd_nibble_adj u_adj (.a(sh[NUM_W+DIG_W*i +: DIG_W]), .y(adj[NUM_W+DIG_W*i +: DIG_W]));
  end
  assign gly = glyph_code(bus.thuns, bus.huns, bus.tens, bus.ones);
`ifdef BCD2BIN_ERRCHK_EN
  assign bad = (bus.thuns > 4'd9) || (bus.huns > 4'd9) || (bus.tens > 4'd9) || (bus.ones > 4'd9);
`else
  assign bad = 1'b0;
`endif
  // state, shift register and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      cnt <= '0;
      number <= '0;
      func <= FN_NUM;
      err <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      cnt <= cnt_n;
      number <= number_n;
      func <= func_n;
      err <= err_n;
    end
  end
  // accept/classify in IDLE or DONE, one shift per clock in SHIFT; results only move on entry to DONE
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n = cnt;
    number_n = number;
    func_n = func;
    err_n = err;
    if (state == SHIFT) begin
      shift_n = adj;
      cnt_n = cnt + 1'b1;
      if (cnt == CNT_W'(ITER - 1)) begin
        state_n = DONE;
        number_n = adj[NUM_W-1:0];
        func_n = FN_NUM;
        err_n = 1'b0;
      end
    end else if (bus.start) begin
      if (gly != FN_NUM || bad) begin
        state_n = DONE;
        number_n = '0;
        func_n = gly;
        err_n = bad && gly == FN_NUM;
      end else begin
        state_n = SHIFT;
        shift_n = {bus.thuns, bus.huns, bus.tens, bus.ones, {NUM_W{1'b0}}};
        cnt_n = '0;
      end
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  assign bus.number = number;
  assign bus.func = func;
  assign bus.err = err;
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
endmodule
